// File: rtl/vc_port_arbiter_pkg.sv
// Shared types and constants for the two-VC weighted port arbiter.
package vc_port_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StServeVc0 = 2'd1,
    StServeVc1 = 2'd2
  } arb_state_e;

  // Bit position of the destination-port field inside a FIFO head word.
  localparam int unsigned DestBit      = 4;
  localparam int unsigned DefWeightVc0 = 3;
  localparam int unsigned DefWeightVc1 = 1;
  localparam int unsigned CntW         = 3;

endpackage

// File: rtl/fc_block_tracker.sv
// Per-destination blocked flag driven by downstream pause/continue pulses.
module fc_block_tracker (
  input  logic clk,
  input  logic reset,
  input  logic i_pause,
  input  logic i_continue,
  output logic o_blocked
);

  logic r_blocked;

  // Pause wins over a simultaneous continue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blocked <= 1'b0;
    end else if (i_pause) begin
      r_blocked <= 1'b1;
    end else if (i_continue) begin
      r_blocked <= 1'b0;
    end
  end

  assign o_blocked = r_blocked;

endmodule

// File: rtl/vc_port_arbiter.sv
// Weighted round-robin arbiter popping two VC FIFOs onto one registered output,
// skipping a VC whose head word targets a paused destination.
module vc_port_arbiter
  import vc_port_arbiter_pkg::*;
#(
  parameter int unsigned BUS_SIZE   = 5,
  parameter int unsigned WEIGHT_VC0 = DefWeightVc0,
  parameter int unsigned WEIGHT_VC1 = DefWeightVc1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active,
  input  logic              empty_VC0,
  input  logic              empty_VC1,
  input  logic [BUS_SIZE:0] data_VC0,
  input  logic [BUS_SIZE:0] data_VC1,
  input  logic              pause_D0,
  input  logic              pause_D1,
  input  logic              continue_D0,
  input  logic              continue_D1,
  output logic              pop_VC0,
  output logic              pop_VC1,
  output logic [BUS_SIZE:0] data_out,
  output logic              valid_out,
  output logic              vc_out,
  output logic              blocked_D0,
  output logic              blocked_D1
);

  localparam logic [CntW-1:0] Weight0   = CntW'(WEIGHT_VC0);
  localparam logic [CntW-1:0] Weight0M1 = CntW'(WEIGHT_VC0 - 1);
  localparam logic [CntW-1:0] Weight1M1 = CntW'(WEIGHT_VC1 - 1);

  arb_state_e        r_state, w_state_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic [1:0]        w_blocked;
  logic              w_elig0, w_elig1;
  logic              w_pop0, w_pop1;
  logic              r_valid, r_vc;
  logic [BUS_SIZE:0] r_data;

  fc_block_tracker u_blk_d0 (
    .clk        (clk),
    .reset      (reset),
    .i_pause    (pause_D0),
    .i_continue (continue_D0),
    .o_blocked  (w_blocked[0])
  );

  fc_block_tracker u_blk_d1 (
    .clk        (clk),
    .reset      (reset),
    .i_pause    (pause_D1),
    .i_continue (continue_D1),
    .o_blocked  (w_blocked[1])
  );

  assign w_elig0 = !empty_VC0 && !w_blocked[data_VC0[DestBit]];
  assign w_elig1 = !empty_VC1 && !w_blocked[data_VC1[DestBit]];

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_pop0    = 1'b0;
    w_pop1    = 1'b0;
    if (!active) begin
      w_state_d = StIdle;
    end else begin
      case (r_state)
        StIdle: begin
          w_state_d = StServeVc0;
          w_cnt_d   = Weight0;
        end
        StServeVc0: begin
          if (w_elig0 && r_cnt != '0) begin
            w_pop0  = 1'b1;
            w_cnt_d = r_cnt - 1'b1;
          end else if (w_elig1) begin
            w_pop1    = 1'b1;
            w_state_d = StServeVc1;
            w_cnt_d   = Weight1M1;
          end else if (w_elig0) begin
            // Quota spent but the other VC has nothing to send: keep going.
            w_pop0  = 1'b1;
            w_cnt_d = Weight0M1;
          end
        end
        StServeVc1: begin
          if (w_elig1 && r_cnt != '0) begin
            w_pop1  = 1'b1;
            w_cnt_d = r_cnt - 1'b1;
          end else if (w_elig0) begin
            w_pop0    = 1'b1;
            w_state_d = StServeVc0;
            w_cnt_d   = Weight0M1;
          end else if (w_elig1) begin
            w_pop1  = 1'b1;
            w_cnt_d = Weight1M1;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= Weight0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_vc    <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= w_pop0 | w_pop1;
      if (w_pop0) begin
        r_data <= data_VC0;
        r_vc   <= 1'b0;
      end else if (w_pop1) begin
        r_data <= data_VC1;
        r_vc   <= 1'b1;
      end
    end
  end

  assign pop_VC0    = w_pop0;
  assign pop_VC1    = w_pop1;
  assign data_out   = r_data;
  assign valid_out  = r_valid;
  assign vc_out     = r_vc;
  assign blocked_D0 = w_blocked[0];
  assign blocked_D1 = w_blocked[1];

endmodule

// File: tb/tb_vc_port_arbiter.sv
// Self-checking bench: emulated VC FIFOs, a cycle-level scoreboard model and
// directed plus randomized scenarios for vc_port_arbiter.
module tb_vc_port_arbiter;

  localparam int unsigned BusSize = 5;
  localparam int W0 = 3;
  localparam int W1 = 1;

  logic clk;
  logic reset, active;
  logic empty_VC0, empty_VC1;
  logic [BusSize:0] data_VC0, data_VC1, data_out;
  logic pause_D0, pause_D1, continue_D0, continue_D1;
  logic pop_VC0, pop_VC1, valid_out, vc_out, blocked_D0, blocked_D1;

  vc_port_arbiter #(
    .BUS_SIZE   (BusSize),
    .WEIGHT_VC0 (W0),
    .WEIGHT_VC1 (W1)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .active      (active),
    .empty_VC0   (empty_VC0),
    .empty_VC1   (empty_VC1),
    .data_VC0    (data_VC0),
    .data_VC1    (data_VC1),
    .pause_D0    (pause_D0),
    .pause_D1    (pause_D1),
    .continue_D0 (continue_D0),
    .continue_D1 (continue_D1),
    .pop_VC0     (pop_VC0),
    .pop_VC1     (pop_VC1),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .vc_out      (vc_out),
    .blocked_D0  (blocked_D0),
    .blocked_D1  (blocked_D1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Emulated FIFOs and reference model (serving: 0 none, 1 VC0, 2 VC1).
  logic [BusSize:0] q0[$];
  logic [BusSize:0] q1[$];
  int               m_serving;
  int               m_credit;
  bit   [1:0]       m_blk;
  bit               m_valid;
  bit               m_vc;
  logic [BusSize:0] m_data;
  int               obs[$];
  longint           obs_t[$];
  int               n_vec = 0;
  int               n_err = 0;

  function automatic int weight(int v);
    return (v == 0) ? W0 : W1;
  endfunction

  function automatic logic [BusSize:0] mk_word(bit dest);
    logic [BusSize:0] w;
    w = BusSize'($urandom);
    w[4] = dest;
    return w;
  endfunction

  // Scoreboard: compares registered outputs and pops, then advances the model.
  always @(negedge clk) begin
    bit elig[2];
    int exp_pop;
    int cur;
    if (!reset) begin
      n_vec += 5;
      if (valid_out !== m_valid) begin
        n_err++; $display("FAIL valid_out: got %b expected %b t=%0t", valid_out, m_valid, $time);
      end
      if (vc_out !== m_vc) begin
        n_err++; $display("FAIL vc_out: got %b expected %b t=%0t", vc_out, m_vc, $time);
      end
      if (data_out !== m_data) begin
        n_err++; $display("FAIL data_out: got %h expected %h t=%0t", data_out, m_data, $time);
      end
      if (blocked_D0 !== m_blk[0]) begin
        n_err++; $display("FAIL blocked_D0: got %b expected %b t=%0t", blocked_D0, m_blk[0], $time);
      end
      if (blocked_D1 !== m_blk[1]) begin
        n_err++; $display("FAIL blocked_D1: got %b expected %b t=%0t", blocked_D1, m_blk[1], $time);
      end
      elig[0] = (q0.size() > 0) && !m_blk[q0[0][4]];
      elig[1] = (q1.size() > 0) && !m_blk[q1[0][4]];
      exp_pop = -1;
      if (!active) begin
        m_serving = 0;
      end else if (m_serving == 0) begin
        m_serving = 1;
        m_credit  = W0;
      end else begin
        cur = m_serving - 1;
        if (elig[cur] && m_credit > 0) begin
          exp_pop = cur;
          m_credit--;
        end else if (elig[1-cur]) begin
          exp_pop   = 1 - cur;
          m_serving = 2 - cur;
          m_credit  = weight(1 - cur) - 1;
        end else if (elig[cur]) begin
          exp_pop  = cur;
          m_credit = weight(cur) - 1;
        end
      end
      n_vec += 2;
      if (pop_VC0 !== (exp_pop == 0)) begin
        n_err++; $display("FAIL pop_VC0: got %b expected %b t=%0t", pop_VC0, exp_pop == 0, $time);
      end
      if (pop_VC1 !== (exp_pop == 1)) begin
        n_err++; $display("FAIL pop_VC1: got %b expected %b t=%0t", pop_VC1, exp_pop == 1, $time);
      end
      if (pop_VC0 === 1'b1 || pop_VC1 === 1'b1) begin
        obs.push_back(pop_VC1 ? 1 : 0);
        obs_t.push_back($time);
      end
      m_valid = (exp_pop >= 0);
      if (exp_pop == 0) begin
        m_data = q0.pop_front(); m_vc = 1'b0;
      end else if (exp_pop == 1) begin
        m_data = q1.pop_front(); m_vc = 1'b1;
      end
      if (pause_D0) m_blk[0] = 1'b1; else if (continue_D0) m_blk[0] = 1'b0;
      if (pause_D1) m_blk[1] = 1'b1; else if (continue_D1) m_blk[1] = 1'b0;
    end
  end

  task automatic model_reset();
    m_serving = 0;
    m_credit  = W0;
    m_blk     = '0;
    m_valid   = 1'b0;
    m_vc      = 1'b0;
    m_data    = '0;
  endtask

  // Present FIFO heads for this cycle and advance to just after the next edge.
  task automatic next_cycle();
    empty_VC0 = (q0.size() == 0);
    empty_VC1 = (q1.size() == 0);
    data_VC0  = (q0.size() > 0) ? q0[0] : '0;
    data_VC1  = (q1.size() > 0) ? q1[0] : '0;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    model_reset();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    q0.delete(); q1.delete();
    q0.push_back(mk_word(1'b0));
    active = 1'b1;
    reset  = 1'b1;
    model_reset();
    #2;
    n_vec += 4;
    if (valid_out !== 1'b0 || vc_out !== 1'b0) begin
      n_err++; $display("FAIL reset_regs: got valid=%b vc=%b expected 0 0", valid_out, vc_out);
    end
    if (data_out !== '0) begin
      n_err++; $display("FAIL reset_data: got %h expected 0", data_out);
    end
    if (blocked_D0 !== 1'b0 || blocked_D1 !== 1'b0) begin
      n_err++; $display("FAIL reset_blk: got %b%b expected 00", blocked_D1, blocked_D0);
    end
    if (pop_VC0 !== 1'b0 || pop_VC1 !== 1'b0) begin
      n_err++; $display("FAIL reset_pop: got %b%b expected 00", pop_VC1, pop_VC0);
    end
    repeat (2) begin
      next_cycle();
      n_vec++;
      if (pop_VC0 !== 1'b0 || valid_out !== 1'b0) begin
        n_err++; $display("FAIL reset_hold: got pop=%b valid=%b expected 0 0", pop_VC0, valid_out);
      end
    end
    reset = 1'b0;
    next_cycle();
    next_cycle();
  endtask

  task automatic test_weighted();
    int pat[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    q0.delete(); q1.delete();
    repeat (8) begin
      q0.push_back(mk_word(1'b0));
      q1.push_back(mk_word(1'b0));
    end
    active = 1'b1;
    apply_reset();
    obs.delete();
    repeat (20) next_cycle();
    n_vec++;
    if (obs.size() < 8) begin
      n_err++; $display("FAIL weighted_count: got %0d pops expected >= 8", obs.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_vec++;
        if (obs[i] != pat[i]) begin
          n_err++; $display("FAIL weighted_order[%0d]: got VC%0d expected VC%0d", i, obs[i], pat[i]);
        end
      end
    end
  endtask

  task automatic test_vc1_only();
    q0.delete(); q1.delete();
    repeat (3) q1.push_back(mk_word(1'($urandom)));
    apply_reset();
    obs.delete(); obs_t.delete();
    repeat (8) next_cycle();
    n_vec++;
    if (obs.size() != 3) begin
      n_err++; $display("FAIL vc1_only_count: got %0d pops expected 3", obs.size());
    end else begin
      n_vec += 2;
      if (obs[0] != 1 || obs[1] != 1 || obs[2] != 1) begin
        n_err++; $display("FAIL vc1_only_vc: got %0d%0d%0d expected 111", obs[0], obs[1], obs[2]);
      end
      if (obs_t[2] - obs_t[0] != 20) begin
        n_err++; $display("FAIL vc1_only_gap: got span %0d expected 20", obs_t[2] - obs_t[0]);
      end
    end
  endtask

  task automatic test_pause();
    int n0;
    q0.delete(); q1.delete();
    repeat (4) begin
      q0.push_back(mk_word(1'b1));
      q1.push_back(mk_word(1'b0));
    end
    apply_reset();
    obs.delete();
    pause_D1 = 1'b1;
    next_cycle();
    pause_D1 = 1'b0;
    repeat (6) next_cycle();
    n0 = 0;
    foreach (obs[i]) if (obs[i] == 0) n0++;
    n_vec += 3;
    if (blocked_D1 !== 1'b1) begin
      n_err++; $display("FAIL pause_blk: got %b expected 1", blocked_D1);
    end
    if (n0 != 0 || obs.size() != 4) begin
      n_err++; $display("FAIL pause_serve: got vc0=%0d total=%0d expected 0 4", n0, obs.size());
    end
    continue_D1 = 1'b1;
    next_cycle();
    continue_D1 = 1'b0;
    next_cycle();
    if (obs.size() != 5 || obs[obs.size()-1] != 0) begin
      n_err++; $display("FAIL pause_resume: got total=%0d expected 5 ending in VC0", obs.size());
    end
    repeat (4) next_cycle();
  endtask

  task automatic test_pause_continue_same();
    pause_D0 = 1'b1; continue_D0 = 1'b1;
    next_cycle();
    pause_D0 = 1'b0; continue_D0 = 1'b0;
    n_vec++;
    if (blocked_D0 !== 1'b1) begin
      n_err++; $display("FAIL same_cycle_blk: got %b expected 1", blocked_D0);
    end
    continue_D0 = 1'b1;
    next_cycle();
    continue_D0 = 1'b0;
    n_vec++;
    if (blocked_D0 !== 1'b0) begin
      n_err++; $display("FAIL continue_blk: got %b expected 0", blocked_D0);
    end
  endtask

  task automatic test_active_drop();
    q0.delete(); q1.delete();
    repeat (8) begin
      q0.push_back(mk_word(1'b0));
      q1.push_back(mk_word(1'b1));
    end
    active = 1'b1;
    apply_reset();
    repeat (3) next_cycle();
    active = 1'b0;
    repeat (2) next_cycle();
    active = 1'b1;
    next_cycle();
    obs.delete();
    repeat (5) next_cycle();
    n_vec++;
    if (obs.size() < 4) begin
      n_err++; $display("FAIL active_restart_count: got %0d pops expected >= 4", obs.size());
    end else begin
      n_vec++;
      if (obs[0] != 0 || obs[1] != 0 || obs[2] != 0 || obs[3] != 1) begin
        n_err++; $display("FAIL active_restart: got %0d%0d%0d%0d expected 0001",
                          obs[0], obs[1], obs[2], obs[3]);
      end
    end
  endtask

  task automatic test_reset_midburst();
    q0.delete(); q1.delete();
    repeat (6) q0.push_back(mk_word(1'b0));
    active = 1'b1;
    apply_reset();
    pause_D1 = 1'b1;
    next_cycle();
    pause_D1 = 1'b0;
    next_cycle();
    n_vec++;
    if (valid_out !== 1'b1 || blocked_D1 !== 1'b1) begin
      n_err++; $display("FAIL midburst_pre: got valid=%b blk1=%b expected 1 1", valid_out, blocked_D1);
    end
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if (valid_out !== 1'b0 || blocked_D1 !== 1'b0 || pop_VC0 !== 1'b0) begin
      n_err++; $display("FAIL midburst_reset: got valid=%b blk1=%b pop0=%b expected 0 0 0",
                        valid_out, blocked_D1, pop_VC0);
    end
    model_reset();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_random();
    q0.delete(); q1.delete();
    active = 1'b1;
    apply_reset();
    repeat (400) begin
      if (q0.size() < 3 && $urandom_range(0, 3) != 0) q0.push_back(mk_word(1'($urandom)));
      if (q1.size() < 3 && $urandom_range(0, 3) != 0) q1.push_back(mk_word(1'($urandom)));
      pause_D0    = ($urandom_range(0, 9) == 0);
      pause_D1    = ($urandom_range(0, 9) == 0);
      continue_D0 = ($urandom_range(0, 3) == 0);
      continue_D1 = ($urandom_range(0, 3) == 0);
      active      = ($urandom_range(0, 19) != 0);
      next_cycle();
    end
    pause_D0 = 1'b0; pause_D1 = 1'b0; continue_D0 = 1'b0; continue_D1 = 1'b0;
    active = 1'b1;
  endtask

  initial begin
    reset = 1'b1; active = 1'b0;
    empty_VC0 = 1'b1; empty_VC1 = 1'b1; data_VC0 = '0; data_VC1 = '0;
    pause_D0 = 1'b0; pause_D1 = 1'b0; continue_D0 = 1'b0; continue_D1 = 1'b0;
    model_reset();
    test_reset();
    test_weighted();
    test_vc1_only();
    test_pause();
    test_pause_continue_same();
    test_active_drop();
    test_reset_midburst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
